param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised modulo-N up/down counter with synchronous load, count enable and wrap/saturate selection.
- Successor to the fixed mod-10 up/down counter. Width and modulus are generics.
- Adds enable, saturation mode, terminal-count output for cascading, a wrap-event pulse and a load-error flag.
- Drives the count datapath of the counter subsystem. The counter interface and its clocking blocks are extended to carry the new signals.

Parameters:
- WIDTH, 4: bit width of data_in and data_out.
- MODULUS, 10: count range is 0..MODULUS-1. Legal values are 2 <= MODULUS <= 2**WIDTH. Any other value is an elaboration-time fatal error.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  count enable; no effect on load.
- load  input  1  synchronous load of data_in.
- data_in  input  WIDTH  load value.
- mode  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  0 = wrap at boundary, 1 = saturate (hold) at boundary.
- data_out  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse on a wrap event.
- load_err  output  1  registered one-cycle pulse on an out-of-range load.

Behaviour:
- Reset (async, any time, including mid-count or mid-load):
  - data_out=0, wrap=0, load_err=0 immediately.
  - First update happens at the first posedge after reset deasserts.
- Per-posedge priority: load > enable count > hold.
- Load (load=1):
  - If data_in < MODULUS: data_out <= data_in, load_err <= 0.
  - If data_in >= MODULUS: data_out is unchanged and load_err <= 1 for exactly one cycle.
  - In both cases wrap <= 0, and enable, mode and sat_mode are ignored.
- Count up (load=0, enable=1, mode=1):
  - data_out < MODULUS-1: data_out <= data_out+1.
  - data_out == MODULUS-1 and sat_mode=0: data_out <= 0, wrap <= 1.
  - data_out == MODULUS-1 and sat_mode=1: data_out holds, wrap <= 0.
- Count down (load=0, enable=1, mode=0):
  - data_out > 0: data_out <= data_out-1.
  - data_out == 0 and sat_mode=0: data_out <= MODULUS-1, wrap <= 1.
  - data_out == 0 and sat_mode=1: data_out holds, wrap <= 0.
- Hold (load=0, enable=0): data_out holds, wrap <= 0, load_err <= 0.
- wrap and load_err are one-cycle pulses. Each is cleared on the next posedge unless its triggering condition repeats.
- tc = enable & ~load & ((mode & data_out==MODULUS-1) | (~mode & data_out==0)).
  - tc is independent of sat_mode.
  - Cascade rule: a downstream stage's enable = upstream tc.
- Latency: one clock from input sample to data_out, wrap and load_err. tc has zero latency.
- Arithmetic:
  - All compares are unsigned and WIDTH bits wide.
  - data_out never leaves 0..MODULUS-1.
  - No intermediate overflow is allowed when MODULUS == 2**WIDTH; the wrap boundary comes from the MODULUS compare, never from natural rollover.
- mode and sat_mode changes take effect on the next posedge. No internal mode state is kept.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset mid-count: count up to 6, assert reset between edges -> data_out=0, wrap=0, load_err=0 immediately, before the next posedge.
- Up wrap: load 8, enable=1, mode=1, sat_mode=0 -> data_out 9,0,1. wrap=1 only in the cycle data_out=0. tc=1 while data_out=9.
- Down saturate: load 2, mode=0, sat_mode=1, enable=1 for 5 cycles -> data_out 1,0,0,0,0. wrap stays 0. tc=1 while data_out=0.
- Load priority and range: data_out=3; load=1, enable=1, data_in=12 -> data_out stays 3, load_err=1 for one cycle. Then load data_in=7 -> data_out=7, load_err=0.
- Enable gating and mode switch: enable=0 for 3 cycles -> data_out constant, tc=0. Switch mode 1->0 at data_out=5 with enable=1 -> next value 4.
- Full-range modulus (WIDTH=4, MODULUS=16): count up from 14 -> 15,0 with wrap=1. Count down from 0 -> 15 with wrap=1. load 15 accepted with load_err=0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, count enable and wrap/saturate selection.
// Latency: one clock from input sample to data_out/wrap/load_err; tc is combinational (zero latency).
// Backpressure: none; the counter accepts its controls every cycle, and cascading is done by driving a downstream enable from tc.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Reject a modulus that cannot be represented or makes no sense as a counter.
  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $fatal(1, "param_updown_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
    end
  endgenerate

  // Top count value held as a WIDTH-bit constant. When MODULUS == 2**WIDTH it is
  // all-ones, so every boundary test stays a WIDTH-bit compare and never relies
  // on natural rollover.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (data_out == MAX_VAL);
  assign at_zero = (data_out == '0);

  // Terminal count: asserted when the next enabled count step would cross the boundary.
  assign tc = enable & ~load & ((mode & at_max) | (~mode & at_zero));

  // Next-state selection: load beats count, count beats hold; pulses default low.
  always_comb begin
    count_nxt    = data_out;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (data_in <= MAX_VAL) begin
        count_nxt = data_in;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (enable) begin
      if (mode) begin
        if (!at_max) begin
          count_nxt = data_out + WIDTH'(1);
        end else if (!sat_mode) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_nxt = data_out - WIDTH'(1);
        end else if (!sat_mode) begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // Register the count and the two one-cycle event pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data_out <= count_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a mod-10 instance and a full-range mod-16 instance.
// Checks are taken #1 after the rising edge, or #1 after an input change for tc.
// Inputs are driven between edges with blocking assignments.
module tb_param_updown_counter;

  logic       clock;
  logic       reset;

  logic       enable, load, mode, sat_mode;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       tc, wrap, load_err;

  logic       f_enable, f_load, f_mode, f_sat_mode;
  logic [3:0] f_data_in;
  logic [3:0] f_data_out;
  logic       f_tc, f_wrap, f_load_err;

  int n_vec = 0;
  int n_err = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .data_in (data_in),
    .mode    (mode),
    .sat_mode(sat_mode),
    .data_out(data_out),
    .tc      (tc),
    .wrap    (wrap),
    .load_err(load_err)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16)) u_full (
    .clock   (clock),
    .reset   (reset),
    .enable  (f_enable),
    .load    (f_load),
    .data_in (f_data_in),
    .mode    (f_mode),
    .sat_mode(f_sat_mode),
    .data_out(f_data_out),
    .tc      (f_tc),
    .wrap    (f_wrap),
    .load_err(f_load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Check count, wrap and load_err of the mod-10 instance together.
  task automatic chk3(input string tag, input int d, input int w, input int e);
    chk({tag, ".data"}, 32'(data_out), 32'(d));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".lerr"}, 32'(load_err), 32'(e));
  endtask

  initial begin
    reset = 1'b1;
    enable = 0; load = 0; mode = 1; sat_mode = 0; data_in = '0;
    f_enable = 0; f_load = 0; f_mode = 1; f_sat_mode = 0; f_data_in = '0;
    #12;
    chk3("reset", 0, 0, 0);
    chk("reset.full", 32'(f_data_out), 0);
    @(negedge clock);
    reset = 1'b0;

    // Count up to 6, then reset between edges.
    enable = 1;
    repeat (6) step();
    chk("count6", 32'(data_out), 6);
    #3;
    reset = 1'b1;
    #1;
    chk3("midreset", 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    enable = 0;

    // Up wrap from 8.
    load = 1; data_in = 4'd8;
    step();
    chk3("ld8", 8, 0, 0);
    load = 0; enable = 1; mode = 1; sat_mode = 0;
    #1;
    chk("tc@8", 32'(tc), 0);
    step();
    chk3("up9", 9, 0, 0);
    chk("tc@9", 32'(tc), 1);
    step();
    chk3("upwrap0", 0, 1, 0);
    chk("tc@0up", 32'(tc), 0);
    step();
    chk3("up1", 1, 0, 0);

    // Down saturate from 2.
    load = 1; data_in = 4'd2;
    step();
    chk3("ld2", 2, 0, 0);
    load = 0; mode = 0; sat_mode = 1; enable = 1;
    step();
    chk3("dn1", 1, 0, 0);
    chk("tc@1dn", 32'(tc), 0);
    step();
    chk3("dn0", 0, 0, 0);
    chk("tc@0dn", 32'(tc), 1);
    repeat (3) begin
      step();
      chk3("dnsat", 0, 0, 0);
    end

    // Load priority and range.
    load = 1; data_in = 4'd3;
    step();
    chk3("ld3", 3, 0, 0);
    enable = 1; data_in = 4'd12;
    #1;
    chk("tc@load", 32'(tc), 0);
    step();
    chk3("ld12bad", 3, 0, 1);
    data_in = 4'd7;
    step();
    chk3("ld7", 7, 0, 0);
    load = 1; data_in = 4'd10;
    step();
    chk3("ld10bad", 7, 0, 1);
    load = 0; enable = 0;
    step();
    chk3("errclr", 7, 0, 0);

    // Enable gating at the terminal value, then a mode switch.
    load = 1; data_in = 4'd9;
    step();
    load = 0; enable = 0; mode = 1; sat_mode = 0;
    repeat (3) begin
      step();
      chk("gate.data", 32'(data_out), 9);
      chk("gate.tc", 32'(tc), 0);
    end
    load = 1; data_in = 4'd5;
    step();
    load = 0; enable = 1; mode = 1;
    step();
    chk("up6", 32'(data_out), 6);
    mode = 0;
    step();
    chk("switch5", 32'(data_out), 5);
    step();
    chk("switch4", 32'(data_out), 4);

    // Down wrap on the mod-10 instance.
    load = 1; data_in = 4'd0;
    step();
    load = 0; mode = 0; sat_mode = 0; enable = 1;
    step();
    chk3("dnwrap9", 9, 1, 0);
    enable = 0;

    // Full-range modulus 16.
    f_load = 1; f_data_in = 4'd14;
    step();
    chk("f.ld14", 32'(f_data_out), 14);
    f_load = 0; f_enable = 1; f_mode = 1; f_sat_mode = 0;
    step();
    chk("f.up15", 32'(f_data_out), 15);
    chk("f.tc15", 32'(f_tc), 1);
    chk("f.wrap15", 32'(f_wrap), 0);
    step();
    chk("f.up0", 32'(f_data_out), 0);
    chk("f.wrap0", 32'(f_wrap), 1);
    f_mode = 0;
    #1;
    chk("f.tc0dn", 32'(f_tc), 1);
    step();
    chk("f.dn15", 32'(f_data_out), 15);
    chk("f.wrapdn", 32'(f_wrap), 1);
    f_mode = 1; f_sat_mode = 1;
    step();
    chk("f.sat15", 32'(f_data_out), 15);
    chk("f.satwrap", 32'(f_wrap), 0);
    f_enable = 0; f_load = 1; f_data_in = 4'd3;
    step();
    f_data_in = 4'd15;
    step();
    chk("f.ld15", 32'(f_data_out), 15);
    chk("f.ld15err", 32'(f_load_err), 0);
    f_load = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
